// File: rtl/shift_pkg.sv
// Shared types and helpers for the shift_pipe datapath.
// No logic of its own; no latency.
// No flow control.
package shift_pkg;

   typedef enum logic [1:0] {
      SHL  = 2'd0,
      SHR  = 2'd1,
      SSHR = 2'd2,
      ROL  = 2'd3
   } shift_mode_t;

   // Effective direction after a negative signed amount has been folded in.
   typedef enum logic [2:0] {
      LEFT        = 3'd0,
      RIGHT       = 3'd1,
      ARITH_RIGHT = 3'd2,
      ROT_LEFT    = 3'd3,
      ROT_RIGHT   = 3'd4
   } dir_t;

   // Bits needed to index n distinct values (ceil(log2(n))).
   function automatic int clog2_amt(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/shift_pipe_stage.sv
// One register stage of shift_pipe: applies mag bits [LO +: CNT] then registers.
// Latency 1 cycle; optional sticky under SHIFT_PIPE_STICKY_EN.
// Advances when empty or when the downstream stage advances.
module shift_pipe_stage
   import shift_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int MW    = 4,
   parameter int LO    = 0,
   parameter int CNT   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             up_vld,
   input  logic [WIDTH-1:0] up_dat,
   input  logic [MW-1:0]    up_mag,
   input  dir_t             up_dir,
   input  logic             up_fill,
`ifdef SHIFT_PIPE_STICKY_EN
   input  logic             up_sticky,
   output logic             sticky,
`endif
   input  logic             dn_adv,
   output logic             adv,
   output logic             vld,
   output logic [WIDTH-1:0] dat,
   output logic [MW-1:0]    mag,
   output dir_t             dir,
   output logic             fill
);

   logic [WIDTH-1:0]   nd;
   logic [2*WIDTH-1:0] w2;
   int                 sh;
`ifdef SHIFT_PIPE_STICKY_EN
   logic               ns;
`endif

   assign adv = !vld || dn_adv;

   always_comb begin
      nd = up_dat;
      w2 = '0;
      sh = 0;
`ifdef SHIFT_PIPE_STICKY_EN
      ns = up_sticky;
`endif
      for (int k = LO; k < LO + CNT; k++) begin
         if (up_mag[k]) begin
            sh = 1 << k;
            case (up_dir)
               LEFT: nd = (sh >= WIDTH) ? '0 : (nd << sh);
               RIGHT, ARITH_RIGHT: begin
                  if (sh >= WIDTH) begin
`ifdef SHIFT_PIPE_STICKY_EN
                     ns = ns | (|nd);
`endif
                     nd = {WIDTH{up_fill}};
                  end else begin
`ifdef SHIFT_PIPE_STICKY_EN
                     ns = ns | (|(nd & ~({WIDTH{1'b1}} << sh)));
`endif
                     w2 = {{WIDTH{up_fill}}, nd} >> sh;
                     nd = w2[WIDTH-1:0];
                  end
               end
               // Rotate amounts were reduced mod WIDTH at capture, so sh < WIDTH here.
               ROT_LEFT: begin
                  w2 = {nd, nd} << sh;
                  nd = w2[2*WIDTH-1:WIDTH];
               end
               ROT_RIGHT: begin
                  w2 = {nd, nd} >> sh;
                  nd = w2[WIDTH-1:0];
               end
               default: nd = up_dat;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld  <= 1'b0;
         dat  <= '0;
         mag  <= '0;
         dir  <= LEFT;
         fill <= 1'b0;
`ifdef SHIFT_PIPE_STICKY_EN
         sticky <= 1'b0;
`endif
      end else if (adv) begin
         vld <= up_vld;
         if (up_vld) begin
            dat  <= nd;
            mag  <= up_mag;
            dir  <= up_dir;
            fill <= up_fill;
`ifdef SHIFT_PIPE_STICKY_EN
            sticky <= ns;
`endif
         end
      end
   end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SHL/SHR/SSHR/ROL, optional signed amount); SHIFT_PIPE_STICKY_EN adds out_sticky.
// Latency STAGES cycles, one transaction per cycle.
// Valid/ready; in_ready = stage 0 empty or advancing, no in_valid->in_ready path.
module shift_pipe
   import shift_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int AMT_W  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [AMT_W-1:0] in_amt,
   input  logic             in_amt_signed,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef SHIFT_PIPE_STICKY_EN
   output logic             out_sticky,
`endif
   output logic [WIDTH-1:0] out_data
);

   localparam int NB    = clog2_amt(WIDTH + 1);
   localparam int MAGW  = AMT_W + 1;
   localparam int BASE  = NB / STAGES;
   localparam int EXTRA = NB % STAGES;

   logic             neg;
   logic [MAGW-1:0]  mag_full;
   logic [NB-1:0]    eff;
   dir_t             dir0;

   logic [STAGES:0]  s_vld;
   logic [STAGES:0]  s_adv;
   logic [STAGES:0]  s_fill;
   logic [WIDTH-1:0] s_dat [STAGES+1];
   logic [NB-1:0]    s_mag [STAGES+1];
   dir_t             s_dir [STAGES+1];
`ifdef SHIFT_PIPE_STICKY_EN
   logic [STAGES:0]  s_st;
`endif

   assign neg = in_amt_signed && in_amt[AMT_W-1];

   // Normalise to a non-negative magnitude clamped (or reduced mod WIDTH for rotates)
   // into NB bits, so every stage only ever sees in-range shift steps.
   always_comb begin
      mag_full = neg ? (MAGW'(0) - {1'b1, in_amt}) : {1'b0, in_amt};
      case (shift_mode_t'(in_mode))
         SHL:     dir0 = neg ? RIGHT : LEFT;
         SHR:     dir0 = neg ? LEFT : RIGHT;
         SSHR:    dir0 = neg ? LEFT : ARITH_RIGHT;
         default: dir0 = neg ? ROT_RIGHT : ROT_LEFT;
      endcase
      if (dir0 == ROT_LEFT || dir0 == ROT_RIGHT)
         eff = NB'(32'(mag_full) % WIDTH);
      else if (32'(mag_full) >= WIDTH)
         eff = NB'(WIDTH);
      else
         eff = NB'(mag_full);
   end

   assign s_vld[0]  = in_valid;
   assign s_dat[0]  = in_data;
   assign s_mag[0]  = eff;
   assign s_dir[0]  = dir0;
   assign s_fill[0] = (dir0 == ARITH_RIGHT) ? in_data[WIDTH-1] : 1'b0;
`ifdef SHIFT_PIPE_STICKY_EN
   assign s_st[0]   = 1'b0;
`endif
   assign s_adv[STAGES] = out_ready;

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      localparam int CNT = BASE + ((s < EXTRA) ? 1 : 0);
      localparam int LO  = s * BASE + ((s < EXTRA) ? s : EXTRA);
      shift_pipe_stage #(
         .WIDTH (WIDTH),
         .MW    (NB),
         .LO    (LO),
         .CNT   (CNT)
      ) u_stage (
         .clk       (clk),
         .rst       (rst),
         .up_vld    (s_vld[s]),
         .up_dat    (s_dat[s]),
         .up_mag    (s_mag[s]),
         .up_dir    (s_dir[s]),
         .up_fill   (s_fill[s]),
`ifdef SHIFT_PIPE_STICKY_EN
         .up_sticky (s_st[s]),
         .sticky    (s_st[s+1]),
`endif
         .dn_adv    (s_adv[s+1]),
         .adv       (s_adv[s]),
         .vld       (s_vld[s+1]),
         .dat       (s_dat[s+1]),
         .mag       (s_mag[s+1]),
         .dir       (s_dir[s+1]),
         .fill      (s_fill[s+1])
      );
   end

   assign in_ready  = s_adv[0];
   assign out_valid = s_vld[STAGES];
   assign out_data  = s_dat[STAGES];
`ifdef SHIFT_PIPE_STICKY_EN
   assign out_sticky = s_st[STAGES];
`endif

   logic unused_tail;
   assign unused_tail = ^{s_mag[STAGES], s_dir[STAGES], s_fill[STAGES]};

endmodule
